// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte to the keyboard over the
// open-collector clock/data pair and reports acknowledge (done) or failure (error).
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYC = 9600,
    parameter int unsigned TIMEOUT_CYC = 1440000,
    parameter int unsigned FILT        = 8
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       rx_inhibit,
    output logic       done,
    output logic       error
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned IW = $clog2(INHIBIT_CYC + 1);
    localparam int unsigned FW = $clog2(FILT + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        ACK,
        WAITIDLE,
        FAIL
    } state_t;

    logic [1:0]    clk_sync, dat_sync;
    logic          clk_s, dat_s;
    logic          filt_clk, fall;
    logic [FW-1:0] filt_cnt;

    state_t        state, state_n;
    logic [9:0]    shreg, shreg_n;
    logic [3:0]    bitcnt, bitcnt_n;
    logic [TW-1:0] tcnt, tcnt_n, tdec;
    logic [IW-1:0] icnt, icnt_n;
    logic          clk_oe_q, clk_oe_n;
    logic          dat_oe_q, dat_oe_n;
    logic          busy_q, busy_n;
    logic          done_q, done_n;
    logic          error_q, error_n;
    logic          timed;

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

    // Filtered clock only moves after FILT consecutive samples at the new level
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_i};
            dat_sync <= {dat_sync[0], ps2_dat_i};
            fall     <= 1'b0;
            if (clk_s == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILT - 1)) begin
                filt_clk <= clk_s;
                filt_cnt <= '0;
                fall     <= ~clk_s;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bitcnt   <= '0;
            tcnt     <= '0;
            icnt     <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bitcnt   <= bitcnt_n;
            tcnt     <= tcnt_n;
            icnt     <= icnt_n;
            clk_oe_q <= clk_oe_n;
            dat_oe_q <= dat_oe_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            error_q  <= error_n;
        end
    end

    assign timed = (state == RTS) || (state == SHIFT) || (state == ACK) || (state == WAITIDLE);
    assign tdec  = tcnt - 1'b1;

    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        bitcnt_n = bitcnt;
        tcnt_n   = tcnt;
        icnt_n   = icnt;
        clk_oe_n = clk_oe_q;
        dat_oe_n = dat_oe_q;
        busy_n   = busy_q;
        done_n   = 1'b0;
        error_n  = 1'b0;

        if (timed) begin
            tcnt_n = fall ? TW'(TIMEOUT_CYC) : tdec;
        end

        unique case (state)
            IDLE: begin
                clk_oe_n = 1'b0;
                dat_oe_n = 1'b0;
                if (tx_start) begin
                    shreg_n  = {1'b1, ~^tx_data, tx_data};
                    busy_n   = 1'b1;
                    clk_oe_n = 1'b1;
                    icnt_n   = IW'(INHIBIT_CYC - 1);
                    state_n  = INHIBIT;
                end
            end
            INHIBIT: begin
                icnt_n = icnt - 1'b1;
                if (icnt == IW'(1)) begin
                    dat_oe_n = 1'b1;
                end
                if (icnt == '0) begin
                    clk_oe_n = 1'b0;
                    dat_oe_n = 1'b1;
                    tcnt_n   = TW'(TIMEOUT_CYC);
                    state_n  = RTS;
                end
            end
            RTS: begin
                if (fall) begin
                    bitcnt_n = '0;
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
                if (fall) begin
                    dat_oe_n = ~shreg[bitcnt];
                    bitcnt_n = bitcnt + 1'b1;
                    if (bitcnt == 4'd9) begin
                        state_n = ACK;
                    end
                end
            end
            ACK: begin
                if (fall) begin
                    state_n = dat_s ? FAIL : WAITIDLE;
                end
            end
            WAITIDLE: begin
                if (dat_s && filt_clk) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            FAIL: begin
                clk_oe_n = 1'b0;
                dat_oe_n = 1'b0;
                error_n  = 1'b1;
                busy_n   = 1'b0;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Timeout reports directly so error lands exactly TIMEOUT_CYC cycles after the last reload
        if (timed && !fall && tdec == '0 && !done_n) begin
            clk_oe_n = 1'b0;
            dat_oe_n = 1'b0;
            error_n  = 1'b1;
            busy_n   = 1'b0;
            state_n  = IDLE;
        end
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign busy       = busy_q;
    assign rx_inhibit = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and
// compares the bits it sees against frames built from the byte in the bench.
module tb_ps2_host_tx;

    localparam int unsigned INH = 50;
    localparam int unsigned TMO = 1000;
    localparam int unsigned FLT = 8;
    localparam int          H   = 60;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_start = 1'b0;
    logic       bus_clk, bus_dat;
    logic       ps2_clk_oe, ps2_dat_oe, busy, rx_inhibit, done, error;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    assign bus_clk = dev_clk & ~ps2_clk_oe;
    assign bus_dat = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .FILT(FLT)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ps2_clk_i(bus_clk), .ps2_dat_i(bus_dat),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
        .tx_data(tx_data), .tx_start(tx_start),
        .busy(busy), .rx_inhibit(rx_inhibit), .done(done), .error(error)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (done === 1'b1) done_cnt++;
        if (error === 1'b1) err_cnt++;
        if (done === 1'b1 && error === 1'b1) both_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    // Bits on the wire in device sampling order: start, data LSB first, odd parity, stop
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = ($countones(d) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic start_tx(input logic [7:0] d, input string name);
        tx_data  = d;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        vectors++;
        if ({busy, rx_inhibit, ps2_clk_oe} !== 3'b111) begin
            miscompares++;
            $display("FAIL %s accept: busy/inhibit/clk_oe=%b required 111", name, {busy, rx_inhibit, ps2_clk_oe});
        end
    endtask

    task automatic inhibit_phase(input string name, input bit poke);
        int cnt = 0;
        int first = -1;
        while (ps2_clk_oe === 1'b1 && cnt < INH * 4) begin
            if (ps2_dat_oe === 1'b1 && first < 0) first = cnt;
            tx_start = poke && (cnt == 10);
            tx_data  = 8'h55;
            tick(1);
            tx_start = 1'b0;
            cnt++;
        end
        vectors++;
        if (cnt != INH) begin
            miscompares++;
            $display("FAIL %s inhibit_len: got %0d cycles, required %0d", name, cnt, INH);
        end
        vectors++;
        if (first != INH - 1 || ps2_dat_oe !== 1'b1) begin
            miscompares++;
            $display("FAIL %s start_bit: dat_oe first at %0d (now %b), required %0d (1)", name, first, ps2_dat_oe, INH - 1);
        end
    endtask

    task automatic device_clock(input int npulse, input bit ack, input bit glitch, output logic [10:0] seen);
        seen = '0;
        tick(30);
        for (int i = 0; i < npulse; i++) begin
            if (i == 11 && ack) dev_dat = 1'b0;
            dev_clk = 1'b0;
            tick(H);
            if (i < 11) seen[i] = bus_dat;
            dev_clk = 1'b1;
            if (glitch && i == 4) begin
                tick(H / 3);
                dev_clk = 1'b0;
                tick(3);
                dev_clk = 1'b1;
                tick(H - H / 3 - 3);
            end else begin
                tick(H);
            end
        end
        dev_dat = 1'b1;
    endtask

    task automatic wait_end(input string name);
        int cyc = 0;
        while (done !== 1'b1 && error !== 1'b1 && cyc < 500) begin
            tick(1);
            cyc++;
        end
        vectors++;
        if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0 || rx_inhibit !== 1'b0) begin
            miscompares++;
            $display("FAIL %s completion: done=%b error=%b busy=%b inhibit=%b after %0d cycles, required 1 0 0 0",
                     name, done, error, busy, rx_inhibit, cyc);
        end
    endtask

    task automatic check_frame(input logic [7:0] d, input logic [10:0] seen, input string name);
        vectors++;
        if (seen !== model_frame(d)) begin
            miscompares++;
            $display("FAIL %s bits: got %b required %b (stop..start)", name, seen, model_frame(d));
        end
    endtask

    task automatic check_counts(input int d0, input int e0, input int dn, input int en, input string name);
        vectors++;
        if (done_cnt - d0 != dn || err_cnt - e0 != en || both_cnt != 0) begin
            miscompares++;
            $display("FAIL %s pulses: done=%0d error=%0d both=%0d, required %0d %0d 0",
                     name, done_cnt - d0, err_cnt - e0, both_cnt, dn, en);
        end
    endtask

    task automatic test_frame(input logic [7:0] d, input bit glitch, input string name);
        logic [10:0] seen;
        int d0 = done_cnt;
        int e0 = err_cnt;
        start_tx(d, name);
        inhibit_phase(name, 1'b0);
        device_clock(12, 1'b1, glitch, seen);
        wait_end(name);
        check_frame(d, seen, name);
        tick(2);
        check_counts(d0, e0, 1, 0, name);
        vectors++;
        if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin
            miscompares++;
            $display("FAIL %s idle_oe: got %b required 00", name, {ps2_clk_oe, ps2_dat_oe});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        vectors++;
        if ({ps2_clk_oe, ps2_dat_oe, busy, rx_inhibit, done, error} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset outputs: got %b required 000000",
                     {ps2_clk_oe, ps2_dat_oe, busy, rx_inhibit, done, error});
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_parity();
        test_frame(8'hED, 1'b0, "tx_ED");
        test_frame(8'h01, 1'b0, "tx_01");
        test_frame(8'h00, 1'b0, "tx_00");
        test_frame(8'hFF, 1'b0, "tx_FF");
    endtask

    task automatic test_timeout();
        int d0 = done_cnt;
        int e0 = err_cnt;
        int k = 0;
        start_tx(8'hFF, "timeout");
        inhibit_phase("timeout", 1'b0);
        while (error !== 1'b1 && k < 3 * TMO) begin
            tick(1);
            k++;
        end
        vectors++;
        if (k != TMO) begin
            miscompares++;
            $display("FAIL timeout latency: got %0d cycles, required %0d", k, TMO);
        end
        vectors++;
        if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL timeout state: clk_oe/dat_oe/busy=%b required 000", {ps2_clk_oe, ps2_dat_oe, busy});
        end
        tick(2);
        check_counts(d0, e0, 0, 1, "timeout");
    endtask

    task automatic test_nack();
        logic [10:0] seen;
        int d0 = done_cnt;
        int e0 = err_cnt;
        start_tx(8'hF4, "nack");
        inhibit_phase("nack", 1'b0);
        device_clock(12, 1'b0, 1'b0, seen);
        check_frame(8'hF4, seen, "nack");
        tick(20);
        check_counts(d0, e0, 0, 1, "nack");
        vectors++;
        if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL nack state: clk_oe/dat_oe/busy=%b required 000", {ps2_clk_oe, ps2_dat_oe, busy});
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] seen;
        int d0 = done_cnt;
        int e0 = err_cnt;
        start_tx(8'h3C, "b2b_first");
        inhibit_phase("b2b_first", 1'b1);
        device_clock(12, 1'b1, 1'b0, seen);
        wait_end("b2b_first");
        check_frame(8'h3C, seen, "b2b_first");
        start_tx(8'hC7, "b2b_second");
        inhibit_phase("b2b_second", 1'b0);
        device_clock(12, 1'b1, 1'b0, seen);
        wait_end("b2b_second");
        check_frame(8'hC7, seen, "b2b_second");
        tick(2);
        check_counts(d0, e0, 2, 0, "b2b");
    endtask

    task automatic test_reset_mid();
        logic [10:0] seen;
        int d0 = done_cnt;
        int e0 = err_cnt;
        logic [7:0] d = 8'h92;
        start_tx(d, "reset_mid");
        inhibit_phase("reset_mid", 1'b0);
        device_clock(4, 1'b0, 1'b0, seen);
        vectors++;
        if (ps2_dat_oe !== ~d[2]) begin
            miscompares++;
            $display("FAIL reset_mid bit2: dat_oe=%b required %b", ps2_dat_oe, ~d[2]);
        end
        reset = 1'b1;
        tick(1);
        vectors++;
        if ({ps2_clk_oe, ps2_dat_oe, busy, done, error} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_mid outputs: got %b required 00000", {ps2_clk_oe, ps2_dat_oe, busy, done, error});
        end
        reset = 1'b0;
        tick(5);
        check_counts(d0, e0, 0, 0, "reset_mid");
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            logic [7:0] d;
            d = 8'($urandom);
            test_frame(d, (n == 1), $sformatf("rand_%02h", d));
        end
    endtask

    initial begin
        test_reset();
        test_parity();
        test_timeout();
        test_nack();
        test_back_to_back();
        test_reset_mid();
        test_frame(8'hA5, 1'b1, "glitch");
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
